// File: rtl/conv_sequencer_pkg.sv
// conv_sequencer_pkg
// Shared types and frame-geometry helpers for the convolver frame sequencer.
//   seq_state_t : sequencer FSM state encoding
//   calc_npix   : number of input pixels in a W x W frame
//   calc_nout   : number of convolution results for a W x W frame, K x K kernel, stride S
package conv_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FEED  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_t;

    function automatic int calc_npix(input int w);
        return w * w;
    endfunction

    // Integer division: positions that do not fit a whole kernel are dropped.
    function automatic int calc_nout(input int w, input int k, input int s);
        int side;
        side = (w - k) / s + 1;
        return side * side;
    endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if
// Pixel input stream and result output stream of the frame sequencer.
//   in_valid/in_data/in_ready    : raster-order pixel stream into the sequencer
//   out_valid/out_data/out_ready : convolution results leaving the output FIFO
// Modports:
//   slave  : the sequencer's view
//   master : the pixel source / result sink view
interface conv_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/conv_sequencer_fifo.sv
// sync_fifo
// Single-clock FIFO holding convolution results until the downstream takes them.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data (ignored when full)
//   pop        : retire the head entry (ignored when empty)
//   pop_data   : current head entry
//   full/empty : occupancy flags
//   count      : number of entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer
// Frame-level controller for one convolver instance: latches weights/bias on
// start, streams W*W pixels into the convolver under clock-enable control,
// captures each valid result into a small FIFO and pulses done at frame end.
//   clk, global_rst_n          : clock, asynchronous active-low reset
//   start                      : frame request, honoured only when idle
//   weight_i, bias_i           : kernel weights / bias, latched on start
//   busy, done                 : frame in progress / one-cycle completion pulse
//   conv_rst, conv_ce          : convolver synchronous clear and clock-enable
//   conv_in, conv_weight, conv_bias : data to the convolver
//   conv_op, conv_valid        : convolver result and its valid flag
//   strm (slave)               : pixel input stream and result output stream
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_CLEAR | one cycle of conv_rst, counters cleared
// ST_FEED  | pixels streamed into the convolver, results captured
// ST_DRAIN | all pixels fed; wait for the FIFO to empty, then pulse done
module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int W          = 28,
    parameter int K          = 3,
    parameter int S          = 1,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         global_rst_n,
    input  logic                         start,
    input  logic [K*K*DATA_WIDTH-1:0]    weight_i,
    input  logic [DATA_WIDTH-1:0]        bias_i,
    output logic                         busy,
    output logic                         done,
    output logic                         conv_rst,
    output logic                         conv_ce,
    output logic [DATA_WIDTH-1:0]        conv_in,
    output logic [K*K*DATA_WIDTH-1:0]    conv_weight,
    output logic [DATA_WIDTH-1:0]        conv_bias,
    input  logic [DATA_WIDTH-1:0]        conv_op,
    input  logic                         conv_valid,
    conv_sequencer_if.slave              strm
);
    localparam int NPIX  = calc_npix(W);
    localparam int NOUT  = calc_nout(W, K, S);
    localparam int PIX_W = $clog2(NPIX + 1);
    localparam int OUT_W = $clog2(NOUT + 1);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int LVL_W = CNT_W + 1;

    localparam logic [PIX_W-1:0] NPIX_C    = PIX_W'(NPIX);
    localparam logic [OUT_W-1:0] NOUT_C    = OUT_W'(NOUT);
    localparam logic [LVL_W-1:0] LVL_LIMIT = LVL_W'(OUT_DEPTH - 2);

    seq_state_t        state;
    logic [PIX_W-1:0]  pix_cnt;
    logic [OUT_W-1:0]  out_cnt;
    logic              ce_q;
    logic              err_cnt_mismatch;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [LVL_W-1:0]  fifo_level;
    logic              in_ready_c;
    logic              in_hs;
    logic              push;
    logic              pop;

    // ce_q marks a result still in flight inside the convolver; counting it
    // keeps one FIFO slot free for it, so a push never meets a full FIFO.
    always_comb begin
        fifo_level = {1'b0, fifo_count} + LVL_W'(ce_q);
        in_ready_c = (state == ST_FEED) && (pix_cnt < NPIX_C) && (fifo_level <= LVL_LIMIT);
        in_hs      = in_ready_c && strm.in_valid;
        // Only the cycle right after a ce pulse carries a fresh result; a
        // stalled convolver keeps conv_valid high and must not be re-captured.
        push       = (state == ST_FEED) && ce_q && conv_valid && !fifo_full;
        pop        = strm.out_ready && !fifo_empty;
    end

    assign strm.in_ready  = in_ready_c;
    assign strm.out_valid = !fifo_empty;
    assign conv_ce        = in_hs;
    assign conv_in        = in_hs ? strm.in_data : '0;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (global_rst_n),
        .push      (push),
        .push_data (conv_op),
        .pop       (pop),
        .pop_data  (strm.out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state            <= ST_IDLE;
            pix_cnt          <= '0;
            out_cnt          <= '0;
            ce_q             <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            conv_rst         <= 1'b1;
            conv_weight      <= '0;
            conv_bias        <= '0;
            err_cnt_mismatch <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    conv_rst <= 1'b0;
                    if (start) begin
                        conv_weight <= weight_i;
                        conv_bias   <= bias_i;
                        conv_rst    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    conv_rst <= 1'b0;
                    pix_cnt  <= '0;
                    out_cnt  <= '0;
                    ce_q     <= 1'b0;
                    state    <= ST_FEED;
                end
                ST_FEED: begin
                    ce_q <= in_hs;
                    if (in_hs) begin
                        pix_cnt <= pix_cnt + PIX_W'(1);
                    end
                    if (push) begin
                        out_cnt <= out_cnt + OUT_W'(1);
                    end
                    // Wait for the last in-flight result before draining.
                    if ((pix_cnt == NPIX_C) && !ce_q) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                        if (out_cnt != NOUT_C) begin
                            err_cnt_mismatch <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    conv_rst <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer
// Bench for conv_sequencer with W=5, K=3, S=1, OUT_DEPTH=4. A streaming
// convolver model sits on the conv_* ports; expected results are computed
// directly from each frame's pixels, weights and bias as window sums.
module tb_conv_sequencer;
    localparam int DW    = 16;
    localparam int W     = 5;
    localparam int K     = 3;
    localparam int S     = 1;
    localparam int DEPTH = 4;
    localparam int NPIX  = W * W;
    localparam int OSIDE = (W - K) / S + 1;
    localparam int NOUT  = OSIDE * OSIDE;
    localparam int WBITS = K * K * DW;

    logic             clk = 1'b0;
    logic             global_rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WBITS-1:0] weight_i = '0;
    logic [DW-1:0]    bias_i = '0;
    logic             busy;
    logic             done;
    logic             conv_rst;
    logic             conv_ce;
    logic [DW-1:0]    conv_in;
    logic [WBITS-1:0] conv_weight;
    logic [DW-1:0]    conv_bias;
    logic [DW-1:0]    conv_op = '0;
    logic             conv_valid = 1'b0;

    conv_sequencer_if #(.DATA_WIDTH(DW)) sif();

    conv_sequencer #(
        .DATA_WIDTH (DW),
        .W          (W),
        .K          (K),
        .S          (S),
        .OUT_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .start        (start),
        .weight_i     (weight_i),
        .bias_i       (bias_i),
        .busy         (busy),
        .done         (done),
        .conv_rst     (conv_rst),
        .conv_ce      (conv_ce),
        .conv_in      (conv_in),
        .conv_weight  (conv_weight),
        .conv_bias    (conv_bias),
        .conv_op      (conv_op),
        .conv_valid   (conv_valid),
        .strm         (sif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [DW-1:0]    frame_pix [NPIX];
    logic [DW-1:0]    exp_q [$];
    logic [WBITS-1:0] exp_w = '0;
    logic [DW-1:0]    exp_b = '0;
    bit               exp_busy = 0;
    int               popped = 0;
    int               frame_pops = 0;
    int               rst_cycles = 0;
    int               done_total = 0;
    int               first_lit = -1;
    int               cv_produced = 0;

    task automatic check(input bit ok, input string name, input logic [191:0] act, input logic [191:0] expv);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Streaming convolver: holds state while ce is low, emits a result one
    // cycle after the pixel that completes a kernel window.
    logic [DW-1:0] cv_pix [NPIX];
    int            cv_cnt = 0;
    always @(posedge clk) begin
        int r;
        int c;
        int acc;
        if (!global_rst_n) cv_produced = 0;
        if (conv_rst) begin
            cv_cnt = 0;
            conv_valid <= 1'b0;
            conv_op    <= '0;
        end else if (conv_ce) begin
            if (cv_cnt < NPIX) begin
                cv_pix[cv_cnt] = conv_in;
                r = cv_cnt / W;
                c = cv_cnt % W;
                if (r >= K-1 && c >= K-1 && ((r-(K-1)) % S) == 0 && ((c-(K-1)) % S) == 0) begin
                    acc = int'(conv_bias);
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++)
                            acc += int'(conv_weight[(ky*K+kx)*DW +: DW]) *
                                   int'(cv_pix[(r-K+1+ky)*W + (c-K+1+kx)]);
                    conv_op    <= acc[DW-1:0];
                    conv_valid <= 1'b1;
                    cv_produced++;
                end else begin
                    conv_valid <= 1'b0;
                end
            end
            cv_cnt++;
        end
    end

    // Per-cycle compare against the frame model.
    always @(negedge clk) begin
        int occ;
        logic [DW-1:0] e;
        if (!global_rst_n) begin
            exp_busy   = 0;
            popped     = 0;
            frame_pops = 0;
            rst_cycles = 0;
            exp_q.delete();
        end else begin
            occ = cv_produced - popped;
            check(conv_ce == (sif.in_valid && sif.in_ready), "conv_ce_vs_handshake",
                  conv_ce, sif.in_valid && sif.in_ready);
            if (conv_ce) check(conv_in == sif.in_data, "conv_in_pass", conv_in, sif.in_data);
            if (conv_rst) check(!conv_ce, "ce_during_clear", conv_ce, 0);
            check(occ <= DEPTH, "occupancy_max", occ, DEPTH);
            if (sif.in_ready) check(occ <= DEPTH-2, "in_ready_throttle", occ, DEPTH-2);
            if (exp_busy) begin
                if (conv_rst) rst_cycles++;
                check(conv_weight == exp_w, "weights_latched", conv_weight, exp_w);
                check(conv_bias == exp_b, "bias_latched", conv_bias, exp_b);
            end else begin
                check(!sif.out_valid && !sif.in_ready, "idle_quiet", {sif.out_valid, sif.in_ready}, 0);
            end
            if (sif.out_valid && sif.out_ready) begin
                if (exp_q.size() == 0) begin
                    check(0, "extra_output", sif.out_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(sif.out_data == e, "out_data", sif.out_data, e);
                    if (first_lit >= 0 && frame_pops == 0)
                        check(sif.out_data == DW'(first_lit), "first_output_literal", sif.out_data, first_lit);
                end
                popped++;
                frame_pops++;
            end
            if (done) begin
                check(exp_busy, "done_without_frame", exp_busy, 1);
                check(exp_q.size() == 0, "outputs_missing_at_done", exp_q.size(), 0);
                check(frame_pops == NOUT, "outputs_per_frame", frame_pops, NOUT);
                check(rst_cycles == 1, "clear_cycles", rst_cycles, 1);
                done_total++;
                frame_pops = 0;
                rst_cycles = 0;
                exp_busy   = 0;
            end
            check(busy == exp_busy, "busy", busy, exp_busy);
            if (start && !exp_busy) begin
                exp_busy = 1;
                exp_w    = weight_i;
                exp_b    = bias_i;
            end
        end
    end

    function automatic logic [WBITS-1:0] fill_w(input int v);
        logic [WBITS-1:0] r;
        for (int i = 0; i < K*K; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    task automatic build_expected(input logic [WBITS-1:0] wv, input logic [DW-1:0] b);
        int acc;
        for (int oy = 0; oy < OSIDE; oy++)
            for (int ox = 0; ox < OSIDE; ox++) begin
                acc = int'(b);
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        acc += int'(wv[(ky*K+kx)*DW +: DW]) *
                               int'(frame_pix[(oy*S+ky)*W + ox*S+kx]);
                exp_q.push_back(acc[DW-1:0]);
            end
    endtask

    task automatic scramble_cfg();
        for (int i = 0; i < K*K; i++) weight_i[i*DW +: DW] = DW'($urandom);
        bias_i = DW'($urandom);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that took start.
    task automatic start_frame(input logic [WBITS-1:0] wv, input logic [DW-1:0] b);
        weight_i = wv;
        bias_i   = b;
        start    = 1'b1;
        build_expected(wv, b);
        @(posedge clk); #1;
        start = 1'b0;
        scramble_cfg();
    endtask

    task automatic check_reset_outputs();
        check(busy == 0, "rst_busy", busy, 0);
        check(done == 0, "rst_done", done, 0);
        check(sif.in_ready == 0, "rst_in_ready", sif.in_ready, 0);
        check(conv_ce == 0, "rst_conv_ce", conv_ce, 0);
        check(sif.out_valid == 0, "rst_out_valid", sif.out_valid, 0);
        check(conv_rst == 1, "rst_conv_rst", conv_rst, 1);
        check(conv_weight == 0, "rst_conv_weight", conv_weight, 0);
        check(conv_bias == 0, "rst_conv_bias", conv_bias, 0);
        check(conv_in == 0, "rst_conv_in", conv_in, 0);
    endtask

    task automatic drive_frame(input int vpct, input int opct, input int hold,
                               input bit start_mid, input int rst_at);
        int pidx = 0;
        int cyc = 0;
        bit fin = 0;
        bit hs;
        bit mid_done = 0;
        bit aborted = 0;
        while (!fin && !aborted && cyc < 2000) begin
            sif.in_valid  = (pidx < NPIX) && ($urandom_range(99) < vpct);
            sif.in_data   = (pidx < NPIX) ? frame_pix[pidx] : DW'($urandom);
            sif.out_ready = (cyc >= hold) && ($urandom_range(99) < opct);
            start = 1'b0;
            if (start_mid && !mid_done && pidx == 8) begin
                start    = 1'b1;
                mid_done = 1;
            end
            @(negedge clk);
            hs  = sif.in_valid && sif.in_ready;
            fin = done;
            if (rst_at >= 0 && pidx == rst_at) begin
                global_rst_n = 1'b0;
                #1;
                check_reset_outputs();
                sif.in_valid  = 1'b0;
                sif.out_ready = 1'b0;
                start         = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                global_rst_n = 1'b1;
                @(posedge clk); #1;
                aborted = 1;
            end else begin
                @(posedge clk); #1;
                if (hs) pidx++;
                cyc++;
            end
        end
        start        = 1'b0;
        sif.in_valid = 1'b0;
        if (!aborted) check(fin, "frame_done_timeout", fin, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.out_ready = 1'b0;
        for (int i = 0; i < NPIX; i++) frame_pix[i] = DW'(i + 1);

        #23;
        check_reset_outputs();
        @(posedge clk); #1;
        global_rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: ones, bias 0, ramp pixels, full throughput
        first_lit = 63;
        start_frame(fill_w(1), 16'd0);
        check(exp_q[0] == 16'd63, "model_first_window", exp_q[0], 63);
        check(exp_q[NOUT-1] == 16'd171, "model_last_window", exp_q[NOUT-1], 171);
        drive_frame(100, 100, 0, 0, -1);

        // 2: random input starvation
        start_frame(fill_w(1), 16'd0);
        drive_frame(50, 100, 0, 0, -1);

        // 3: output backpressure for the first 10 busy cycles
        start_frame(fill_w(1), 16'd0);
        drive_frame(100, 100, 10, 0, -1);

        // 4: start pulsed mid-feed with different weights on weight_i
        start_frame(fill_w(1), 16'd0);
        drive_frame(100, 100, 0, 1, -1);

        // 5: reset at pixel 12, then a clean frame
        start_frame(fill_w(1), 16'd0);
        drive_frame(100, 100, 0, 0, 12);
        check(busy == 0, "post_abort_busy", busy, 0);
        start_frame(fill_w(1), 16'd0);
        drive_frame(100, 100, 0, 0, -1);

        // 6: back-to-back frames, second with weights 2 and bias 5
        start_frame(fill_w(1), 16'd0);
        drive_frame(100, 100, 0, 0, -1);
        first_lit = 131;
        start_frame(fill_w(2), 16'd5);
        drive_frame(100, 100, 0, 0, -1);

        // 7: random pixels/weights/bias with random valid and ready
        first_lit = -1;
        for (int i = 0; i < NPIX; i++) frame_pix[i] = DW'($urandom_range(255));
        begin
            logic [WBITS-1:0] rw;
            for (int i = 0; i < K*K; i++) rw[i*DW +: DW] = DW'($urandom_range(15));
            start_frame(rw, DW'($urandom_range(1000)));
        end
        drive_frame(60, 60, 0, 0, -1);

        repeat (3) @(posedge clk);
        #1;
        check(done_total == 8, "done_pulse_total", done_total, 8);
        check(dut.err_cnt_mismatch == 1'b0, "err_cnt_mismatch", dut.err_cnt_mismatch, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
